// File: rtl/ysyx_axi_arb_pkg.sv
// ysyx_axi_arb_pkg: shared arbiter state encoding, grant tags and strobe-to-size helper
package ysyx_axi_arb_pkg;
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_B} state_t;
    typedef enum logic [1:0] {G_NONE, G_IFU, G_LD, G_ST} grant_t;
    localparam logic [2:0] IFU_SIZE = 3'd2;
    function automatic logic [2:0] strb_size(input logic [7:0] strb);
        return strb == 8'h01 ? 3'd0 : strb == 8'h03 ? 3'd1 : strb == 8'h0F ? 3'd2 : 3'd0;
    endfunction
endpackage

// File: rtl/ysyx_axi_lane.sv
// ysyx_axi_lane: 64-bit bus lane steering for reads (extract) and writes (shift/replicate/strobe)
module ysyx_axi_lane
    import ysyx_axi_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        raddr,
    input  logic [63:0]       rdata,
    output logic [DATA_W-1:0] rd_data,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wd_in,
    input  logic [3:0]        ws_in,
    output logic [63:0]       wdata,
    output logic [7:0]        wstrb
);
    logic [31:0] rhalf, rsh, wsh;
    logic [3:0]  s4;
    always_comb begin
        rhalf = raddr[2] ? rdata[63:32] : rdata[31:0];
        rsh   = rhalf >> {raddr[1:0], 3'b000};
        wsh   = 32'(wd_in) << {waddr[1:0], 3'b000};
        s4    = ws_in << waddr[1:0];
    end
    assign rd_data = DATA_W'(rsh);
    assign wdata   = {wsh, wsh};
    assign wstrb   = waddr[2] ? {s4, 4'b0000} : {4'b0000, s4};
endmodule

// File: rtl/ysyx_axi_arb.sv
// ysyx_axi_arb: single-outstanding AXI master arbitrating IFU reads and LSU loads/stores
module ysyx_axi_arb
    import ysyx_axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic [DATA_W-1:0] ifu_rdata_o,
    output logic              ifu_rvalid_o,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    input  logic [7:0]        lsu_rstrb,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              lsu_rvalid_o,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready_o,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic [2:0]        io_master_arsize,
    output logic              io_master_arvalid,
    input  logic              io_master_arready,
    input  logic [63:0]       io_master_rdata,
    input  logic              io_master_rvalid,
    output logic              io_master_rready,
    output logic [ADDR_W-1:0] io_master_awaddr,
    output logic [2:0]        io_master_awsize,
    output logic              io_master_awvalid,
    input  logic              io_master_awready,
    output logic [63:0]       io_master_wdata,
    output logic [7:0]        io_master_wstrb,
    output logic              io_master_wlast,
    output logic              io_master_wvalid,
    input  logic              io_master_wready,
    input  logic              io_master_bvalid,
    output logic              io_master_bready
);
    state_t            state, state_n;
    grant_t            gnt, gnt_n;
    logic              fair, aw_done, w_done, aw_hs, w_hs;
    logic [DATA_W-1:0] lane_rdata;
    logic [63:0]       lane_wdata;
    logic [7:0]        lane_wstrb;

    assign io_master_rready = 1'b1;
    assign io_master_bready = 1'b1;
    assign aw_hs = io_master_awvalid & io_master_awready;
    assign w_hs  = io_master_wvalid & io_master_wready;

    ysyx_axi_lane #(.DATA_W(DATA_W)) u_lane (
        .raddr   (io_master_araddr[2:0]),
        .rdata   (io_master_rdata),
        .rd_data (lane_rdata),
        .waddr   (lsu_awaddr[2:0]),
        .wd_in   (lsu_wdata),
        .ws_in   (lsu_wstrb[3:0]),
        .wdata   (lane_wdata),
        .wstrb   (lane_wstrb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // A pending IFU fetch that was passed over by an LSU transaction wins the next grant
    always_comb begin
        gnt_n   = G_NONE;
        state_n = state;
        case (state)
            S_IDLE: begin
                if (fair && ifu_arvalid) gnt_n = G_IFU;
                else if (lsu_wvalid)     gnt_n = G_ST;
                else if (lsu_arvalid)    gnt_n = G_LD;
                else if (ifu_arvalid)    gnt_n = G_IFU;
                if (gnt_n == G_ST)        state_n = S_AW;
                else if (gnt_n != G_NONE) state_n = S_AR;
            end
            S_AR: if (io_master_arready) state_n = S_R;
            S_R:  if (io_master_rvalid) state_n = S_IDLE;
            S_AW: if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = S_B;
            S_B:  if (io_master_bvalid) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt               <= G_NONE;
            fair              <= 1'b0;
            aw_done           <= 1'b0;
            w_done            <= 1'b0;
            ifu_rdata_o       <= '0;
            ifu_rvalid_o      <= 1'b0;
            lsu_rdata_o       <= '0;
            lsu_rvalid_o      <= 1'b0;
            lsu_wready_o      <= 1'b0;
            io_master_araddr  <= '0;
            io_master_arsize  <= '0;
            io_master_arvalid <= 1'b0;
            io_master_awaddr  <= '0;
            io_master_awsize  <= '0;
            io_master_awvalid <= 1'b0;
            io_master_wdata   <= '0;
            io_master_wstrb   <= '0;
            io_master_wlast   <= 1'b0;
            io_master_wvalid  <= 1'b0;
        end else begin
            ifu_rvalid_o <= 1'b0;
            ifu_rdata_o  <= '0;
            lsu_rvalid_o <= 1'b0;
            lsu_rdata_o  <= '0;
            lsu_wready_o <= 1'b0;
            case (state)
                S_IDLE: if (gnt_n != G_NONE) begin
                    gnt <= gnt_n;
                    if (gnt_n == G_IFU) fair <= 1'b0;
                    if (gnt_n == G_ST) begin
                        io_master_awaddr  <= lsu_awaddr;
                        io_master_awsize  <= strb_size(lsu_wstrb);
                        io_master_wdata   <= lane_wdata;
                        io_master_wstrb   <= lane_wstrb;
                        io_master_awvalid <= 1'b1;
                        io_master_wvalid  <= 1'b1;
                        io_master_wlast   <= 1'b1;
                    end else begin
                        io_master_araddr  <= gnt_n == G_IFU ? ifu_araddr : lsu_araddr;
                        io_master_arsize  <= gnt_n == G_IFU ? IFU_SIZE : strb_size(lsu_rstrb);
                        io_master_arvalid <= 1'b1;
                    end
                end
                S_AR: if (io_master_arready) io_master_arvalid <= 1'b0;
                S_R: if (io_master_rvalid) begin
                    if (gnt == G_IFU) begin
                        ifu_rvalid_o <= 1'b1;
                        ifu_rdata_o  <= lane_rdata;
                    end else begin
                        lsu_rvalid_o <= 1'b1;
                        lsu_rdata_o  <= lane_rdata;
                        if (ifu_arvalid) fair <= 1'b1;
                    end
                end
                S_AW: begin
                    if (aw_hs) begin
                        io_master_awvalid <= 1'b0;
                        aw_done           <= 1'b1;
                    end
                    if (w_hs) begin
                        io_master_wvalid <= 1'b0;
                        io_master_wlast  <= 1'b0;
                        w_done           <= 1'b1;
                    end
                end
                S_B: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (io_master_bvalid) begin
                        lsu_wready_o <= 1'b1;
                        if (ifu_arvalid) fair <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_axi_arb.sv
// tb_ysyx_axi_arb: directed bench with a response scoreboard for ysyx_axi_arb
module tb_ysyx_axi_arb;
    logic        clk, rst;
    logic [31:0] ifu_araddr, ifu_rdata_o, lsu_araddr, lsu_rdata_o, lsu_awaddr, lsu_wdata;
    logic        ifu_arvalid, ifu_rvalid_o, lsu_arvalid, lsu_rvalid_o, lsu_wvalid, lsu_wready_o;
    logic [7:0]  lsu_rstrb, lsu_wstrb, io_master_wstrb;
    logic [31:0] io_master_araddr, io_master_awaddr;
    logic [2:0]  io_master_arsize, io_master_awsize;
    logic        io_master_arvalid, io_master_arready, io_master_rvalid, io_master_rready;
    logic        io_master_awvalid, io_master_awready, io_master_wlast, io_master_wvalid;
    logic        io_master_wready, io_master_bvalid, io_master_bready;
    logic [63:0] io_master_rdata, io_master_wdata;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
    } resp_t;
    resp_t       sb[$];
    resp_t       e;
    logic [1:0]  mk;
    logic [31:0] md;
    int          vectors = 0;
    int          miscompares = 0;

    ysyx_axi_arb dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
        .ifu_rdata_o(ifu_rdata_o), .ifu_rvalid_o(ifu_rvalid_o),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
        .lsu_rdata_o(lsu_rdata_o), .lsu_rvalid_o(lsu_rvalid_o),
        .lsu_awaddr(lsu_awaddr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_wvalid(lsu_wvalid), .lsu_wready_o(lsu_wready_o),
        .io_master_araddr(io_master_araddr), .io_master_arsize(io_master_arsize),
        .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
        .io_master_rdata(io_master_rdata), .io_master_rvalid(io_master_rvalid),
        .io_master_rready(io_master_rready),
        .io_master_awaddr(io_master_awaddr), .io_master_awsize(io_master_awsize),
        .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
        .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
        .io_master_wlast(io_master_wlast), .io_master_wvalid(io_master_wvalid),
        .io_master_wready(io_master_wready),
        .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ar(input string tag);
        for (int i = 0; i < 10 && !io_master_arvalid; i++) tick();
        chk(tag, io_master_arvalid, 1);
    endtask

    task automatic wait_aw(input string tag);
        for (int i = 0; i < 10 && !io_master_awvalid; i++) tick();
        chk(tag, io_master_awvalid, 1);
    endtask

    // Response monitor: every pulse must match the oldest expected response
    always @(negedge clk) begin
        if (!rst) begin
            if (ifu_rvalid_o || lsu_rvalid_o || lsu_wready_o) begin
                mk = ifu_rvalid_o ? 2'd0 : lsu_rvalid_o ? 2'd1 : 2'd2;
                md = ifu_rvalid_o ? ifu_rdata_o : lsu_rvalid_o ? lsu_rdata_o : 32'h0;
                vectors++;
                assert (sb.size() != 0) else begin
                    miscompares++;
                    $error("FAIL unexpected_resp: observed kind %0d data 0x%0h expected none", mk, md);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    vectors++;
                    assert ({mk, md} === {e.kind, e.data}) else begin
                        miscompares++;
                        $error("FAIL resp: observed kind %0d data 0x%0h expected kind %0d data 0x%0h",
                               mk, md, e.kind, e.data);
                    end
                end
            end
            vectors++;
            assert ((ifu_rvalid_o || ifu_rdata_o == 0) && (lsu_rvalid_o || lsu_rdata_o == 0)) else begin
                miscompares++;
                $error("FAIL idle_rdata: observed ifu 0x%0h lsu 0x%0h expected 0x0", ifu_rdata_o, lsu_rdata_o);
            end
        end
    end

    initial begin
        rst = 1'b1;
        {ifu_araddr, ifu_arvalid, lsu_araddr, lsu_arvalid, lsu_rstrb} = '0;
        {lsu_awaddr, lsu_wdata, lsu_wstrb, lsu_wvalid} = '0;
        {io_master_arready, io_master_rdata, io_master_rvalid} = '0;
        {io_master_awready, io_master_wready, io_master_bvalid} = '0;
        tick();
        tick();
        chk("reset_valids", {io_master_arvalid, io_master_awvalid, io_master_wvalid, io_master_wlast,
                             ifu_rvalid_o, lsu_rvalid_o, lsu_wready_o}, 0);
        chk("reset_ready", {io_master_rready, io_master_bready}, 2'b11);
        chk("reset_addr", {io_master_araddr, io_master_awaddr}, 0);
        rst = 1'b0;
        tick();
        // IFU read of the upper word with delayed arready
        ifu_araddr = 32'h8000_0004;
        ifu_arvalid = 1'b1;
        sb.push_back('{kind: 2'd0, data: 32'h1122_3344});
        wait_ar("ifu_arvalid");
        ifu_arvalid = 1'b0;
        chk("ifu_araddr", io_master_araddr, 32'h8000_0004);
        chk("ifu_arsize", io_master_arsize, 3'd2);
        tick();
        tick();
        chk("ar_hold", {io_master_arvalid, io_master_araddr}, {1'b1, 32'h8000_0004});
        io_master_arready = 1'b1;
        tick();
        io_master_arready = 1'b0;
        chk("ar_drop", io_master_arvalid, 0);
        io_master_rdata = 64'h1122_3344_5566_7788;
        io_master_rvalid = 1'b1;
        tick();
        io_master_rvalid = 1'b0;
        tick();
        // Store and fetch together: store first, then the fetch beats a new load
        lsu_awaddr = 32'h8000_0010;
        lsu_wdata = 32'hDEAD_BEEF;
        lsu_wstrb = 8'h0F;
        lsu_wvalid = 1'b1;
        ifu_araddr = 32'h8000_0100;
        ifu_arvalid = 1'b1;
        wait_aw("st_awvalid");
        lsu_wvalid = 1'b0;
        chk("st_valids", {io_master_awvalid, io_master_wvalid, io_master_wlast, io_master_arvalid}, 4'b1110);
        chk("st_awaddr", io_master_awaddr, 32'h8000_0010);
        chk("st_awsize", io_master_awsize, 3'd2);
        chk("st_wstrb", io_master_wstrb, 8'h0F);
        chk("st_wdata", io_master_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
        io_master_awready = 1'b1;
        io_master_wready = 1'b1;
        tick();
        io_master_awready = 1'b0;
        io_master_wready = 1'b0;
        chk("st_both_done", {io_master_awvalid, io_master_wvalid}, 2'b00);
        sb.push_back('{kind: 2'd2, data: 32'h0});
        io_master_bvalid = 1'b1;
        tick();
        io_master_bvalid = 1'b0;
        lsu_araddr = 32'h8000_0203;
        lsu_rstrb = 8'h01;
        lsu_arvalid = 1'b1;
        wait_ar("fair_arvalid");
        chk("fair_ifu_wins", io_master_araddr, 32'h8000_0100);
        ifu_arvalid = 1'b0;
        io_master_arready = 1'b1;
        tick();
        io_master_arready = 1'b0;
        sb.push_back('{kind: 2'd0, data: 32'h1234_5678});
        io_master_rdata = 64'hCAFE_F00D_1234_5678;
        io_master_rvalid = 1'b1;
        tick();
        io_master_rvalid = 1'b0;
        // Byte load at offset 3
        wait_ar("ld_arvalid");
        lsu_arvalid = 1'b0;
        chk("ld_araddr", io_master_araddr, 32'h8000_0203);
        chk("ld_arsize", io_master_arsize, 3'd0);
        io_master_arready = 1'b1;
        tick();
        io_master_arready = 1'b0;
        sb.push_back('{kind: 2'd1, data: 32'h0000_00AA});
        io_master_rdata = 64'h0000_0000_AABB_CCDD;
        io_master_rvalid = 1'b1;
        tick();
        io_master_rvalid = 1'b0;
        tick();
        // Halfword load from the upper word
        lsu_araddr = 32'h8000_0006;
        lsu_rstrb = 8'h03;
        lsu_arvalid = 1'b1;
        wait_ar("hw_arvalid");
        lsu_arvalid = 1'b0;
        chk("hw_arsize", io_master_arsize, 3'd1);
        io_master_arready = 1'b1;
        tick();
        io_master_arready = 1'b0;
        sb.push_back('{kind: 2'd1, data: 32'h0000_9988});
        io_master_rdata = 64'h9988_7766_0000_0000;
        io_master_rvalid = 1'b1;
        tick();
        io_master_rvalid = 1'b0;
        tick();
        // Byte store to 0x80000007 with awready well ahead of wready
        lsu_awaddr = 32'h8000_0007;
        lsu_wdata = 32'h0000_00AB;
        lsu_wstrb = 8'h01;
        lsu_wvalid = 1'b1;
        wait_aw("sb_awvalid");
        lsu_wvalid = 1'b0;
        chk("sb_awsize", io_master_awsize, 3'd0);
        chk("sb_wstrb", io_master_wstrb, 8'h80);
        chk("sb_wdata_hi", io_master_wdata[63:56], 8'hAB);
        io_master_awready = 1'b1;
        tick();
        io_master_awready = 1'b0;
        chk("sb_aw_only", {io_master_awvalid, io_master_wvalid, io_master_wlast}, 3'b011);
        tick();
        chk("sb_w_held", {io_master_awvalid, io_master_wvalid}, 2'b01);
        io_master_wready = 1'b1;
        tick();
        io_master_wready = 1'b0;
        chk("sb_w_done", io_master_wvalid, 0);
        chk("sb_no_early_ack", lsu_wready_o, 0);
        sb.push_back('{kind: 2'd2, data: 32'h0});
        io_master_bvalid = 1'b1;
        tick();
        io_master_bvalid = 1'b0;
        tick();
        tick();
        // Reset in R: asynchronous clear, late rvalid ignored
        ifu_araddr = 32'h8000_0008;
        ifu_arvalid = 1'b1;
        wait_ar("rst_arvalid");
        ifu_arvalid = 1'b0;
        io_master_arready = 1'b1;
        tick();
        io_master_arready = 1'b0;
        #2 rst = 1'b1;
        #1 chk("rst_async_addr", io_master_araddr, 0);
        chk("rst_async_valid", {io_master_arvalid, ifu_rvalid_o}, 0);
        tick();
        rst = 1'b0;
        io_master_rdata = 64'h5555_6666_7777_8888;
        io_master_rvalid = 1'b1;
        tick();
        io_master_rvalid = 1'b0;
        chk("rst_no_pulse", ifu_rvalid_o, 0);
        tick();
        tick();
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ysyx_axi_arb.md
YSYX_AXI_ARB -- requirements
Module: ysyx_axi_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, requester data width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports ifu_araddr in ADDR_W, ifu_arvalid in 1: IFU read request.
REQ-007 SHALL have ports ifu_rdata_o out DATA_W, ifu_rvalid_o out 1: IFU read response.
REQ-008 SHALL have ports lsu_araddr in ADDR_W, lsu_arvalid in 1, lsu_rstrb in 8: LSU load request.
REQ-009 SHALL have ports lsu_rdata_o out DATA_W, lsu_rvalid_o out 1: LSU load response.
REQ-010 SHALL have ports lsu_awaddr in ADDR_W, lsu_wdata in DATA_W, lsu_wstrb in 8, lsu_wvalid in 1: LSU store request.
REQ-011 SHALL have port lsu_wready_o  out  1  store-complete pulse.
REQ-012 SHALL have AXI AR ports: io_master_araddr out ADDR_W, io_master_arsize out 3, io_master_arvalid out 1, io_master_arready in 1.
REQ-013 SHALL have AXI R ports: io_master_rdata in 64, io_master_rvalid in 1, io_master_rready out 1.
REQ-014 SHALL have AXI AW ports: io_master_awaddr out ADDR_W, io_master_awsize out 3, io_master_awvalid out 1, io_master_awready in 1.
REQ-015 SHALL have AXI W ports: io_master_wdata out 64, io_master_wstrb out 8, io_master_wlast out 1, io_master_wvalid out 1, io_master_wready in 1.
REQ-016 SHALL have AXI B ports: io_master_bvalid in 1, io_master_bready out 1.

Function
REQ-017 SHALL implement FSM IDLE, AR, R, AW, B; exactly one transaction outstanding at any time.
REQ-018 In IDLE, SHALL sample requests and grant by priority LSU store > LSU load > IFU; exception: fair bit set and ifu_arvalid high -> IFU wins.
REQ-019 fair bit SHALL set when an LSU transaction completes while ifu_arvalid is high, and SHALL clear when an IFU grant is issued.
REQ-020 On grant SHALL register address, size, data and strobe; all io_master outputs SHALL come from registers, with arvalid/awvalid asserted the cycle after grant.
REQ-021 arsize/awsize SHALL be 0/1/2 for strobe 8'h01/8'h03/8'h0F, else 0; IFU reads use size 2.
REQ-022 AR: hold arvalid and araddr stable until arready; then go to R.
REQ-023 R: rready constantly 1; on rvalid, pulse the granted requester's rvalid_o for exactly one cycle with data = rdata[63:32] if addr[2] else rdata[31:0], right-shifted by 8*addr[1:0]; then go to IDLE.
REQ-024 AW: assert awvalid and wvalid together, wlast=1; wdata = shifted lsu_wdata replicated in both halves; wstrb = lsu_wstrb[3:0]<<addr[1:0], placed in upper nibble if addr[2].
REQ-025 AW: track aw_done and w_done independently, deasserting each valid once its handshake occurs; go to B when both are done (same cycle allowed).
REQ-026 B: bready constantly 1; on bvalid pulse lsu_wready_o for one cycle, go to IDLE.
REQ-027 Non-granted response outputs SHALL be 0; rdata outputs SHALL be 0 when the matching rvalid_o is 0.
REQ-028 A requester dropping valid mid-transaction SHALL NOT abort the bus transaction; the response pulse is still issued.
REQ-029 Minimum turnaround: the response cycle returns to IDLE; the next grant is evaluated the following cycle.

Reset
REQ-030 On rst: state=IDLE, fair=0, aw_done=w_done=0; all valid/pulse outputs 0; address/data registers 0; rready and bready SHALL be 1 and remain 1 whenever rst is deasserted.

Structure
REQ-031 State encoding and the strobe-to-size function SHALL live in the shared ysyx package/macro header alongside existing bus macros.
REQ-032 Lane steering (read extract, write shift/strobe) SHALL be one sub-module ysyx_axi_lane; the FSM remains in ysyx_axi_arb.

Verification
REQ-033 IFU read 0x80000004, arready after 2 cycles, rdata=0x11223344_55667788 -> ifu_rvalid_o one cycle, ifu_rdata_o=0x11223344.
REQ-034 Simultaneous lsu_wvalid and ifu_arvalid -> AW issued first, lsu_wready_o on bvalid; fair=1; IFU AR next, and it beats a new lsu_arvalid.
REQ-035 Store byte 0xAB to 0x80000007 -> awsize=0, wstrb=8'h80, wdata[63:56]=0xAB.
REQ-036 awready two cycles before wready -> awvalid drops after its handshake, wvalid held until wready; exactly one lsu_wready_o pulse.
REQ-037 rst asserted during R -> outputs cleared asynchronously; after release, late rvalid produces no rvalid_o pulse.
